// File: rtl/cache_nway_plru.sv
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU
// replacement; 4-word lines are refilled over a req/ack backing-memory port.
module cache_nway_plru #(
    parameter int WAYS       = 2,
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam int SETS = 1 << INDEX_BITS;
    localparam int TW   = 13 - INDEX_BITS;
    localparam int LVLS = $clog2(WAYS);
    localparam int WW   = (WAYS > 1) ? LVLS : 1;
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WB, FILL} state_t;
    state_t state, state_next;

    logic [TW-1:0]   tag_mem  [WAYS][SETS];
    logic [15:0]     data_mem [WAYS][SETS][4];
    logic [SETS-1:0] valid_mem [WAYS];
    logic [SETS-1:0] dirty_mem [WAYS];
    logic [PW-1:0]   plru_mem [SETS];

    logic [TW-1:0]         req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [1:0]            req_word;
    logic [15:0]           req_data;
    logic                  req_wr;
    logic [WW-1:0]         victim_q;
    logic [1:0]            word_cnt;
    logic                  missed;
    logic                  multi_seen;

    logic            accept;
    logic            bad_req;
    logic [WAYS-1:0] match;
    logic [WAYS-1:0] eff_valid;
    logic            one_hit;
    logic            multi_hit;
    logic            victim_dirty;
    logic [WW-1:0]   hit_way;
    logic [WW-1:0]   victim_sel;
    logic [PW-1:0]   plru_cur;
    logic [PW-1:0]   plru_upd;

    // Done gates acceptance so a request still held during its Done cycle is not re-taken.
    assign accept  = (state == IDLE) && !Done && (Rd ^ Wr) && !Addr[0];
    assign bad_req = (state == IDLE) && !Done && (Rd | Wr) && ((Rd & Wr) || Addr[0]);
    assign plru_cur = plru_mem[req_index];

    // Tree level l is steered by way bit l, so the root splits even/odd ways.
    always_comb begin
        int hits;
        int node;
        match      = '0;
        eff_valid  = '0;
        hit_way    = '0;
        victim_sel = '0;
        hits       = 0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_mem[w][req_index] && (tag_mem[w][req_index] == req_tag);
            if (match[w]) begin
                hit_way = WW'(w);
                hits    = hits + 1;
            end
        end
        one_hit   = (hits == 1);
        multi_hit = (hits > 1);
        for (int w = 0; w < WAYS; w++)
            eff_valid[w] = valid_mem[w][req_index] && !(multi_hit && match[w]);
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            victim_sel[l] = plru_cur[node-1];
            node = 2 * node + int'(plru_cur[node-1]);
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!eff_valid[w]) victim_sel = WW'(w);
        victim_dirty = eff_valid[victim_sel] && dirty_mem[victim_sel][req_index];
        plru_upd = plru_cur;
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            plru_upd[node-1] = ~hit_way[l];
            node = 2 * node + int'(hit_way[l]);
        end
    end

    always_comb begin
        state_next = state;
        Stall      = (state != IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: if (accept) state_next = COMPARE;
            COMPARE: begin
                if (one_hit)           state_next = IDLE;
                else if (victim_dirty) state_next = WB;
                else                   state_next = FILL;
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[victim_q][req_index], req_index, word_cnt, 1'b0};
                mem_wdata = data_mem[victim_q][req_index][word_cnt];
                if (mem_ack && word_cnt == 2'd3) state_next = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, word_cnt, 1'b0};
                if (mem_ack && word_cnt == 2'd3) state_next = COMPARE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            Done       <= 1'b0;
            CacheHit   <= 1'b0;
            err        <= 1'b0;
            DataOut    <= '0;
            req_tag    <= '0;
            req_index  <= '0;
            req_word   <= '0;
            req_data   <= '0;
            req_wr     <= 1'b0;
            victim_q   <= '0;
            word_cnt   <= '0;
            missed     <= 1'b0;
            multi_seen <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                valid_mem[w] <= '0;
                dirty_mem[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) plru_mem[s] <= '0;
        end else begin
            state    <= state_next;
            Done     <= 1'b0;
            CacheHit <= 1'b0;
            err      <= bad_req;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_tag   <= Addr[15:16-TW];
                        req_index <= Addr[INDEX_BITS+2:3];
                        req_word  <= Addr[2:1];
                        req_data  <= DataIn;
                        req_wr    <= Wr;
                    end
                end
                COMPARE: begin
                    if (one_hit) begin
                        Done       <= 1'b1;
                        CacheHit   <= !missed;
                        err        <= multi_seen;
                        DataOut    <= req_wr ? req_data : data_mem[hit_way][req_index][req_word];
                        plru_mem[req_index] <= plru_upd;
                        if (req_wr) dirty_mem[hit_way][req_index] <= 1'b1;
                        missed     <= 1'b0;
                        multi_seen <= 1'b0;
                    end else begin
                        victim_q <= victim_sel;
                        word_cnt <= '0;
                        missed   <= 1'b1;
                        // Duplicate tags are dropped so the refill leaves exactly one copy.
                        if (multi_hit) begin
                            multi_seen <= 1'b1;
                            for (int w = 0; w < WAYS; w++)
                                if (match[w]) valid_mem[w][req_index] <= 1'b0;
                        end
                    end
                end
                WB: if (mem_ack) word_cnt <= word_cnt + 2'd1;
                FILL: begin
                    if (mem_ack) begin
                        word_cnt <= word_cnt + 2'd1;
                        valid_mem[victim_q][req_index] <= (word_cnt == 2'd3);
                        if (word_cnt == 2'd3) dirty_mem[victim_q][req_index] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == COMPARE && one_hit && req_wr)
            data_mem[hit_way][req_index][req_word] <= req_data;
        if (state == FILL && mem_ack) begin
            data_mem[victim_q][req_index][word_cnt] <= mem_rdata;
            if (word_cnt == 2'd3) tag_mem[victim_q][req_index] <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_nway_plru.sv
// Directed bench for cache_nway_plru: a 2-way and a 4-way instance share one
// stimulus port and one backing-memory model, selected by sel.
module tb_cache_nway_plru;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] addr, data_in, mem_rdata;
    logic        rd, wr, sel, mem_ack;

    logic [15:0] a_data_out, a_mem_addr, a_mem_wdata, b_data_out, b_mem_addr, b_mem_wdata;
    logic        a_done, a_stall, a_hit, a_err, a_mem_req, a_mem_we;
    logic        b_done, b_stall, b_hit, b_err, b_mem_req, b_mem_we;

    cache_nway_plru #(.WAYS(2), .INDEX_BITS(8)) dut2 (
        .clk(clk), .rst(rst), .Addr(addr), .DataIn(data_in),
        .Rd(rd & ~sel), .Wr(wr & ~sel),
        .DataOut(a_data_out), .Done(a_done), .Stall(a_stall), .CacheHit(a_hit), .err(a_err),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ack(mem_ack & ~sel), .mem_rdata(mem_rdata)
    );

    cache_nway_plru #(.WAYS(4), .INDEX_BITS(8)) dut4 (
        .clk(clk), .rst(rst), .Addr(addr), .DataIn(data_in),
        .Rd(rd & sel), .Wr(wr & sel),
        .DataOut(b_data_out), .Done(b_done), .Stall(b_stall), .CacheHit(b_hit), .err(b_err),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ack(mem_ack & sel), .mem_rdata(mem_rdata)
    );

    wire [15:0] data_out  = sel ? b_data_out  : a_data_out;
    wire        done      = sel ? b_done      : a_done;
    wire        stall     = sel ? b_stall     : a_stall;
    wire        hit       = sel ? b_hit       : a_hit;
    wire        err       = sel ? b_err       : a_err;
    wire        mem_req   = sel ? b_mem_req   : a_mem_req;
    wire        mem_we    = sel ? b_mem_we    : a_mem_we;
    wire [15:0] mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    wire [15:0] mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

    int errors = 0;
    int checks = 0;

    // Backing memory: unwritten words read back as their own address.
    logic [15:0] mem_store [logic [15:0]];
    logic [32:0] xfer_log [$];
    int n_rd = 0, n_wr = 0;
    int ack_budget = 1000000;
    int max_delay = 0;
    int wait_cnt = 0;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a;
    endfunction

    function automatic logic [32:0] get_log(input int i);
        if (i < 0 || i >= xfer_log.size()) return 33'h0;
        return xfer_log[i];
    endfunction

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (rst) begin
            wait_cnt = 0;
        end else if (mem_req && ack_budget > 0) begin
            if (wait_cnt > 0) begin
                wait_cnt = wait_cnt - 1;
            end else begin
                mem_ack = 1'b1;
                ack_budget = ack_budget - 1;
                if (mem_we) begin
                    mem_store[mem_addr] = mem_wdata;
                    n_wr = n_wr + 1;
                    xfer_log.push_back({1'b1, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem_val(mem_addr);
                    n_rd = n_rd + 1;
                    xfer_log.push_back({1'b0, mem_addr, mem_rdata});
                end
                wait_cnt = $urandom_range(max_delay, 0);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Holds the request until Done, bounded; returns latency in cycles from the drive edge.
    task automatic do_access(input string tag, input logic is_wr, input logic [15:0] a,
                             input logic [15:0] d, output int lat, output logic hit_o,
                             output logic [15:0] dout_o, output logic stall1);
        logic got;
        got = 1'b0;
        hit_o = 1'b0;
        dout_o = '0;
        stall1 = 1'b0;
        lat = 0;
        @(negedge clk);
        addr = a; data_in = d; rd = !is_wr; wr = is_wr;
        while (lat < 300 && !got) begin
            @(negedge clk);
            lat = lat + 1;
            if (lat == 1) stall1 = stall;
            if (done) begin
                got = 1'b1;
                hit_o = hit;
                dout_o = data_out;
            end
        end
        rd = 1'b0; wr = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
    endtask

    int lat, base_rd, base_wr, qb;
    logic h, st, flag;
    logic [15:0] dout;
    logic [32:0] ent;
    logic [15:0] set_addrs [4];

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0; sel = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_hit", 32'(hit), 0);
        check("rst_err", 32'(err), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_data_out", 32'(data_out), 0);
        sel = 1'b1;
        #1;
        check("rst4_mem_req", 32'(mem_req), 0);
        check("rst4_stall", 32'(stall), 0);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Cold read miss fills the whole line
        base_rd = n_rd; base_wr = n_wr; qb = xfer_log.size();
        do_access("t1", 1'b0, 16'h0012, 16'h0, lat, h, dout, st);
        check("t1_hit", 32'(h), 0);
        check("t1_data", 32'(dout), 32'h0012);
        check("t1_latency", 32'(lat), 7);
        check("t1_fills", 32'(n_rd - base_rd), 4);
        check("t1_wbs", 32'(n_wr - base_wr), 0);
        ent = get_log(qb);
        check("t1_fill0_addr", 32'(ent[31:16]), 32'h0010);
        ent = get_log(qb + 3);
        check("t1_fill3_addr", 32'(ent[31:16]), 32'h0016);

        // Write hit then read hit
        base_rd = n_rd; base_wr = n_wr;
        do_access("t2w", 1'b1, 16'h0012, 16'hBEEF, lat, h, dout, st);
        check("t2w_hit", 32'(h), 1);
        check("t2w_latency", 32'(lat), 2);
        check("t2w_stall", 32'(st), 1);
        do_access("t2r", 1'b0, 16'h0012, 16'h0, lat, h, dout, st);
        check("t2r_hit", 32'(h), 1);
        check("t2r_data", 32'(dout), 32'hBEEF);
        check("t2_no_mem", 32'((n_rd - base_rd) + (n_wr - base_wr)), 0);

        // PLRU on 2 ways: T0,T1,T0,T2 evicts T1 without write-back
        base_wr = n_wr;
        do_access("t3a", 1'b0, 16'h0012, 16'h0, lat, h, dout, st);
        check("t3a_hit", 32'(h), 1);
        do_access("t3b", 1'b0, 16'h0812, 16'h0, lat, h, dout, st);
        check("t3b_hit", 32'(h), 0);
        check("t3b_data", 32'(dout), 32'h0812);
        do_access("t3c", 1'b0, 16'h0012, 16'h0, lat, h, dout, st);
        check("t3c_hit", 32'(h), 1);
        do_access("t3d", 1'b0, 16'h1012, 16'h0, lat, h, dout, st);
        check("t3d_hit", 32'(h), 0);
        check("t3d_data", 32'(dout), 32'h1012);
        check("t3d_no_wb", 32'(n_wr - base_wr), 0);
        do_access("t3e", 1'b0, 16'h0012, 16'h0, lat, h, dout, st);
        check("t3e_t0_kept", 32'(h), 1);
        check("t3e_data", 32'(dout), 32'hBEEF);
        do_access("t3f", 1'b0, 16'h0812, 16'h0, lat, h, dout, st);
        check("t3f_t1_gone", 32'(h), 0);
        do_access("t3g", 1'b0, 16'h1012, 16'h0, lat, h, dout, st);
        check("t3g_hit", 32'(h), 0);
        do_access("t3h", 1'b0, 16'h0812, 16'h0, lat, h, dout, st);
        check("t3h_hit", 32'(h), 1);
        // Set now holds T2' and T1 with PLRU on the dirty-free T2 way; rebuild T0 dirty state
        do_access("t3i", 1'b1, 16'h0012, 16'hBEEF, lat, h, dout, st);
        check("t3i_miss", 32'(h), 0);
        do_access("t3j", 1'b0, 16'h0812, 16'h0, lat, h, dout, st);
        check("t3j_hit", 32'(h), 1);
        base_wr = n_wr; base_rd = n_rd; qb = xfer_log.size();
        do_access("t3k", 1'b0, 16'h1812, 16'h0, lat, h, dout, st);
        check("t3k_hit", 32'(h), 0);
        check("t3k_data", 32'(dout), 32'h1812);
        check("t3k_wbs", 32'(n_wr - base_wr), 4);
        check("t3k_fills", 32'(n_rd - base_rd), 4);
        ent = get_log(qb);
        check("t3k_wb0", 32'({ent[32], ent[31:16]}), 32'h10010);
        ent = get_log(qb + 1);
        check("t3k_wb1_addr", 32'(ent[31:16]), 32'h0012);
        check("t3k_wb1_data", 32'(ent[15:0]), 32'hBEEF);
        ent = get_log(qb + 3);
        check("t3k_wb3", 32'({ent[32], ent[31:16]}), 32'h10016);
        ent = get_log(qb + 4);
        check("t3k_fill0", 32'({ent[32], ent[31:16]}), 32'h01810);
        do_access("t3l", 1'b0, 16'h0012, 16'h0, lat, h, dout, st);
        check("t3l_hit", 32'(h), 0);
        check("t3l_data", 32'(dout), 32'hBEEF);

        // Illegal requests
        base_rd = n_rd; base_wr = n_wr;
        @(negedge clk);
        addr = 16'h0012; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        check("t4_err_rdwr", 32'(err), 1);
        check("t4_done_rdwr", 32'(done), 0);
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_req || done || stall) flag = 1'b1;
        end
        check("t4_quiet", 32'(flag), 0);
        addr = 16'h0013; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("t4_err_odd", 32'(err), 1);
        check("t4_stall_odd", 32'(stall), 0);
        @(negedge clk);
        check("t4_err_pulse", 32'(err), 0);
        do_access("t4r", 1'b0, 16'h0012, 16'h0, lat, h, dout, st);
        check("t4r_hit", 32'(h), 1);
        check("t4r_latency", 32'(lat), 2);
        check("t4_no_mem", 32'((n_rd - base_rd) + (n_wr - base_wr)), 0);

        // Reset in the middle of a fill
        base_rd = n_rd; ack_budget = 3;
        @(negedge clk);
        addr = 16'h2012; rd = 1'b1; wr = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 60 && !flag; i++) begin
            @(posedge clk);
            if (n_rd - base_rd >= 3) flag = 1'b1;
        end
        check("t5_three_words", 32'(flag), 1);
        @(negedge clk);
        check("t5_req_before_rst", 32'(mem_req), 1);
        rst = 1'b1; rd = 1'b0;
        #1;
        check("t5_req_dropped", 32'(mem_req), 0);
        check("t5_stall_dropped", 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0; ack_budget = 1000000;
        base_rd = n_rd;
        do_access("t5r", 1'b0, 16'h2012, 16'h0, lat, h, dout, st);
        check("t5r_hit", 32'(h), 0);
        check("t5r_data", 32'(dout), 32'h2012);
        check("t5r_fills", 32'(n_rd - base_rd), 4);

        // 4-way PLRU with random ack delays
        sel = 1'b1; max_delay = 5;
        set_addrs[0] = 16'h0028; set_addrs[1] = 16'h0828;
        set_addrs[2] = 16'h1028; set_addrs[3] = 16'h1828;
        for (int i = 0; i < 4; i++) begin
            do_access("t6fill", 1'b0, set_addrs[i], 16'h0, lat, h, dout, st);
            check("t6fill_hit", 32'(h), 0);
            check("t6fill_data", 32'(dout), 32'(set_addrs[i]));
        end
        for (int i = 0; i < 3; i++) begin
            do_access("t6touch", 1'b0, set_addrs[i], 16'h0, lat, h, dout, st);
            check("t6touch_hit", 32'(h), 1);
            check("t6touch_latency", 32'(lat), 2);
        end
        base_wr = n_wr;
        do_access("t6new", 1'b0, 16'h2028, 16'h0, lat, h, dout, st);
        check("t6new_hit", 32'(h), 0);
        check("t6new_data", 32'(dout), 32'h2028);
        check("t6new_no_wb", 32'(n_wr - base_wr), 0);
        for (int i = 0; i < 3; i++) begin
            do_access("t6kept", 1'b0, set_addrs[i], 16'h0, lat, h, dout, st);
            check("t6kept_hit", 32'(h), 1);
            check("t6kept_data", 32'(dout), 32'(set_addrs[i]));
        end
        do_access("t6evicted", 1'b0, 16'h1828, 16'h0, lat, h, dout, st);
        check("t6evicted_hit", 32'(h), 0);
        check("t6evicted_data", 32'(dout), 32'h1828);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
